// File: rtl/spi_slave_if_if.sv
// Bus bundle for spi_slave_if: SPI pins plus the parallel rx/tx words exchanged with the RAM.
// The err output exists only when SPI_SLAVE_ERR_EN is defined.
interface spi_slave_if_if #(parameter int DATA_W = 8);
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
`ifdef SPI_SLAVE_ERR_EN
  logic              err;

  modport slave  (input SS_n, MOSI, tx_data, tx_valid, output MISO, rx_data, rx_valid, err);
  modport master (output SS_n, MOSI, tx_data, tx_valid, input MISO, rx_data, rx_valid, err);
`else
  modport slave  (input SS_n, MOSI, tx_data, tx_valid, output MISO, rx_data, rx_valid);
  modport master (output SS_n, MOSI, tx_data, tx_valid, input MISO, rx_data, rx_valid);
`endif
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave front end: rx word + rx_valid one cycle after its last bit, MISO first bit one cycle after tx_valid.
// No backpressure; SS_n high aborts any frame. Optional err pulse output under SPI_SLAVE_ERR_EN.
module spi_slave_if #(
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  spi_slave_if_if.slave bus
);

  localparam int CW = $clog2(DATA_W + 3);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SHIFT_OUT, DONE
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W:0]   r_rx_sr;
  logic [DATA_W-1:0] r_tx_sr;
  logic [DATA_W+1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_miso;
  logic              r_rd_addr_seen;

  logic              w_rx_last;
  logic              w_tx_last;
  logic [DATA_W+1:0] w_rx_word;

  // The final bit is taken straight from MOSI, so the shift register only holds DATA_W+1 bits.
  assign w_rx_last = (r_cnt == CW'(DATA_W + 1));
  assign w_tx_last = (r_cnt == CW'(DATA_W));
  assign w_rx_word = {r_rx_sr, bus.MOSI};

  assign bus.MISO     = r_miso;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;

`ifdef SPI_SLAVE_ERR_EN
  logic r_err;
  assign bus.err = r_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_rx_sr        <= '0;
      r_tx_sr        <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_miso         <= 1'b0;
      r_rd_addr_seen <= 1'b0;
`ifdef SPI_SLAVE_ERR_EN
      r_err          <= 1'b0;
`endif
    end else begin
      r_rx_valid <= 1'b0;
`ifdef SPI_SLAVE_ERR_EN
      r_err      <= 1'b0;
`endif
      if (r_state != IDLE && bus.SS_n) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_miso  <= 1'b0;
`ifdef SPI_SLAVE_ERR_EN
        if (r_state == CHK_CMD || r_state == WRITE || r_state == READ_ADD ||
            r_state == READ_DATA || (r_state == SHIFT_OUT && !w_tx_last))
          r_err <= 1'b1;
`endif
      end else begin
        case (r_state)
          IDLE: begin
            r_miso <= 1'b0;
            r_cnt  <= '0;
            if (!bus.SS_n) r_state <= CHK_CMD;
          end
          CHK_CMD: begin
            r_cnt <= '0;
            if (!bus.MOSI)          r_state <= WRITE;
            else if (r_rd_addr_seen) r_state <= READ_DATA;
            else                     r_state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (w_rx_last) begin
              r_rx_data  <= w_rx_word;
              r_rx_valid <= 1'b1;
              r_cnt      <= '0;
              if (r_state == READ_DATA) begin
                r_rd_addr_seen <= 1'b0;
                r_state        <= WAIT_TX;
              end else begin
                if (r_state == READ_ADD) r_rd_addr_seen <= 1'b1;
                r_state <= DONE;
              end
`ifdef SPI_SLAVE_ERR_EN
              if ((r_state == READ_ADD  && w_rx_word[DATA_W+1:DATA_W] != 2'b10) ||
                  (r_state == READ_DATA && w_rx_word[DATA_W+1:DATA_W] != 2'b11) ||
                  (r_state == WRITE     && w_rx_word[DATA_W+1]))
                r_err <= 1'b1;
`endif
            end else begin
              r_rx_sr <= {r_rx_sr[DATA_W-1:0], bus.MOSI};
              r_cnt   <= r_cnt + CW'(1);
            end
          end
          WAIT_TX: begin
            r_miso <= 1'b0;
            if (bus.tx_valid) begin
              r_miso  <= bus.tx_data[DATA_W-1];
              r_tx_sr <= {bus.tx_data[DATA_W-2:0], 1'b0};
              r_cnt   <= CW'(1);
              r_state <= SHIFT_OUT;
            end
          end
          SHIFT_OUT: begin
            // r_cnt counts bits already presented on MISO
            if (w_tx_last) begin
              r_miso  <= 1'b0;
              r_cnt   <= '0;
              r_state <= DONE;
            end else begin
              r_miso  <= r_tx_sr[DATA_W-1];
              r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
              r_cnt   <= r_cnt + CW'(1);
            end
          end
          DONE: begin
            r_miso <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_miso  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
